// File: rtl/brake_input_conditioner_if.sv
// Pedal-side signal bundle between the raw brake switch and the brake light controller.
// master drives the raw switch; slave (the conditioner) drives the cleaned outputs.
interface brake_input_conditioner_if;
    logic       brakeSwitchRaw;
    logic       brakeActive;
    logic       brakeEvent;
    logic [7:0] bounceCount;

    modport master (
        output brakeSwitchRaw,
        input  brakeActive,
        input  brakeEvent,
        input  bounceCount
    );

    modport slave (
        input  brakeSwitchRaw,
        output brakeActive,
        output brakeEvent,
        output bounceCount
    );
endinterface

// File: rtl/brake_input_conditioner.sv
// Brake pedal conditioner: 2-flop synchroniser, debounce FSM, minimum-on stretcher.
// Optional apply flash pattern on brakeActive when BRAKE_FLASH_EN is defined.
module brake_input_conditioner #(
    parameter int DEBOUNCE_CYCLES   = 500000,
    parameter int MIN_ON_CYCLES     = 12500000,
    parameter int FLASH_HALF_CYCLES = 3750000,
    parameter int FLASH_COUNT       = 3,
    parameter int CNT_W             = 24
) (
    input  logic                      c50M,
    input  logic                      reset_n,
    brake_input_conditioner_if.slave  bus
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] PRESS_DB = 3'd1;
    localparam logic [2:0] ON       = 3'd2;
    localparam logic [2:0] REL_DB   = 3'd3;
    localparam logic [2:0] HOLD     = 3'd4;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_LOAD = CNT_W'(MIN_ON_CYCLES - 1);

    logic             syncMeta;
    logic             sync;
    logic [2:0]       state;
    logic [2:0]       stateNext;
    logic [CNT_W-1:0] dbCnt;
    logic [CNT_W-1:0] dbCntNext;
    logic [CNT_W-1:0] minCnt;
    logic [CNT_W-1:0] minCntNext;
    logic [7:0]       bounceNext;
    logic             eventNext;
    logic             activeNext;
    logic             pending;
    logic             waitLevel;
    logic             dbExpire;
    logic             apply;

    assign pending   = (state == PRESS_DB) || (state == REL_DB);
    assign waitLevel = (state == PRESS_DB);
    assign dbExpire  = (sync == waitLevel) && (dbCnt == DB_LAST);
    assign apply     = (state == PRESS_DB) && (stateNext == ON);

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        stateNext  = state;
        bounceNext = bus.bounceCount;
        case (state)
            IDLE:     if (sync) stateNext = PRESS_DB;
            PRESS_DB: begin
                if (!sync) begin
                    stateNext = IDLE;
                    if (bus.bounceCount != 8'hFF) bounceNext = bus.bounceCount + 8'd1;
                end else if (dbExpire) begin
                    stateNext = ON;
                end
            end
            ON:       if (!sync) stateNext = REL_DB;
            REL_DB: begin
                if (sync)          stateNext = ON;
                else if (dbExpire) stateNext = (minCnt == '0) ? IDLE : HOLD;
            end
            HOLD: begin
                if (sync)                stateNext = ON;
                else if (minCnt == '0)   stateNext = IDLE;
            end
            default:  stateNext = IDLE;
        endcase
    end

    always_comb begin
        dbCntNext = '0;
        if (pending && (stateNext == state) && (sync == waitLevel)) dbCntNext = dbCnt + 1'b1;

        minCntNext = minCnt;
        if (apply)
            minCntNext = MIN_LOAD;
        else if ((state == ON || state == REL_DB || state == HOLD) && minCnt != '0)
            minCntNext = minCnt - 1'b1;

        eventNext = apply;
    end

`ifdef BRAKE_FLASH_EN
    localparam logic [CNT_W-1:0] FLASH_HALF_LAST = CNT_W'(FLASH_HALF_CYCLES - 1);
    localparam logic [CNT_W-1:0] FLASH_IDX_LAST  = CNT_W'(2 * FLASH_COUNT - 1);

    logic             flashing;
    logic             flashingNext;
    logic [CNT_W-1:0] flashCnt;
    logic [CNT_W-1:0] flashCntNext;
    logic [CNT_W-1:0] flashIdx;
    logic [CNT_W-1:0] flashIdxNext;
    logic             flashKeep;

    // The pattern survives a pending release but is dropped on HOLD/IDLE or any return to ON.
    assign flashKeep = flashing && (stateNext == ON || stateNext == REL_DB)
                       && !(state == REL_DB && stateNext == ON);

    always_comb begin
        flashingNext = 1'b0;
        flashCntNext = '0;
        flashIdxNext = '0;
        if (apply) begin
            flashingNext = 1'b1;
        end else if (flashKeep) begin
            flashingNext = 1'b1;
            flashIdxNext = flashIdx;
            flashCntNext = flashCnt + 1'b1;
            if (flashCnt == FLASH_HALF_LAST) begin
                flashCntNext = '0;
                if (flashIdx == FLASH_IDX_LAST) begin
                    flashingNext = 1'b0;
                    flashIdxNext = '0;
                end else begin
                    flashIdxNext = flashIdx + 1'b1;
                end
            end
        end
    end

    // Even half-periods of the pattern are the dark phases.
    always_comb begin
        activeNext = (stateNext == ON || stateNext == REL_DB || stateNext == HOLD)
                     && !(flashingNext && !flashIdxNext[0]);
    end

    always_ff @(posedge c50M or negedge reset_n) begin
        if (!reset_n) begin
            flashing <= 1'b0;
            flashCnt <= '0;
            flashIdx <= '0;
        end else begin
            flashing <= flashingNext;
            flashCnt <= flashCntNext;
            flashIdx <= flashIdxNext;
        end
    end
`else
    always_comb begin
        activeNext = (stateNext == ON || stateNext == REL_DB || stateNext == HOLD);
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge c50M or negedge reset_n) begin
        if (!reset_n) begin
            syncMeta        <= 1'b0;
            sync            <= 1'b0;
            state           <= IDLE;
            dbCnt           <= '0;
            minCnt          <= '0;
            bus.brakeActive <= 1'b0;
            bus.brakeEvent  <= 1'b0;
            bus.bounceCount <= 8'd0;
        end else begin
            syncMeta        <= bus.brakeSwitchRaw;
            sync            <= syncMeta;
            state           <= stateNext;
            dbCnt           <= dbCntNext;
            minCnt          <= minCntNext;
            bus.brakeActive <= activeNext;
            bus.brakeEvent  <= eventNext;
            bus.bounceCount <= bounceNext;
        end
    end

endmodule
